sccb_slave: RTL and testbench

SCCB_SLAVE -- requirements
Module: sccb_slave

---
 rtl/sccb_slave.sv | 202 ++++++++++++++++++++
 tb/tb_sccb_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
// SCCB (I2C-compatible) register-access slave: device address match, sub-address
// pointer, auto-incrementing burst writes and reads, open-drain SDA, no clock stretching.
module sccb_slave #(
    parameter logic [6:0] DEVICE_ID = 7'h21,
    parameter bit         ACK_EN    = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       o_reg_we,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTE_W);
    // Level driven during the acknowledge slot: pull low, or stay released.
    localparam logic ACK_LVL = ACK_EN ? 1'b0 : 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        SUB_ADDR,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t            state;
    logic              scl_s1, scl_s2, scl_h;
    logic              sda_s1, sda_s2, sda_h;
    logic [BYTE_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              rw;
    logic              inc_pend;

    logic scl_rise, scl_fall, start_det, stop_det;
    logic [BYTE_W-1:0] rx_byte;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= i_scl;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= i_sda;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  =  scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 &  scl_h;
    assign start_det =  scl_s2 &  sda_h & ~sda_s2;
    assign stop_det  =  scl_s2 & ~sda_h &  sda_s2;
    assign rx_byte   = {shreg[BYTE_W-2:0], sda_s2};

    // Protocol FSM; START/STOP override any bit-level activity.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            o_sda       <= 1'b1;
            o_reg_we    <= 1'b0;
            o_reg_addr  <= 8'h00;
            o_reg_wdata <= 8'h00;
            o_busy      <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            inc_pend    <= 1'b0;
        end else begin
            o_reg_we <= 1'b0;
            // Pointer advances the cycle after each write strobe.
            if (inc_pend) begin
                o_reg_addr <= o_reg_addr + 8'd1;
                inc_pend   <= 1'b0;
            end

            if (start_det) begin
                state   <= DEV_ADDR;
                bit_cnt <= '0;
                o_sda   <= 1'b1;
                o_busy  <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                o_sda   <= 1'b1;
                o_busy  <= 1'b0;
            end else begin
                case (state)
                    DEV_ADDR, SUB_ADDR, WDATA: begin
                        if (scl_rise && bit_cnt < FULL_CNT) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (state == WDATA && bit_cnt == LAST_BIT) begin
                                o_reg_wdata <= rx_byte;
                                o_reg_we    <= 1'b1;
                                inc_pend    <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == FULL_CNT) begin
                            bit_cnt <= '0;
                            if (state == DEV_ADDR) begin
                                if (shreg[BYTE_W-1:1] == DEVICE_ID) begin
                                    state <= DEV_ACK;
                                    rw    <= shreg[0];
                                    o_sda <= ACK_LVL;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == SUB_ADDR) begin
                                o_reg_addr <= shreg;
                                state      <= SUB_ACK;
                                o_sda      <= ACK_LVL;
                            end else begin
                                state <= WDATA_ACK;
                                o_sda <= ACK_LVL;
                            end
                        end
                    end

                    DEV_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shreg   <= {i_reg_rdata[BYTE_W-2:0], 1'b0};
                                o_sda   <= i_reg_rdata[BYTE_W-1];
                                bit_cnt <= CNT_W'(1);
                                state   <= RDATA;
                            end else begin
                                o_sda   <= 1'b1;
                                bit_cnt <= '0;
                                state   <= SUB_ADDR;
                            end
                        end
                    end

                    SUB_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            o_sda   <= 1'b1;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == FULL_CNT) begin
                                o_sda <= 1'b1;
                                state <= RDATA_ACK;
                            end else begin
                                o_sda   <= shreg[BYTE_W-1];
                                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end

                    RDATA_ACK: begin
                        // Advance on ACK at the rising edge so read data is settled by the fall.
                        if (scl_rise) begin
                            if (sda_s2) begin
                                state <= IGNORE;
                            end else begin
                                o_reg_addr <= o_reg_addr + 8'd1;
                            end
                        end else if (scl_fall) begin
                            shreg   <= {i_reg_rdata[BYTE_W-2:0], 1'b0};
                            o_sda   <= i_reg_rdata[BYTE_W-1];
                            bit_cnt <= CNT_W'(1);
                            state   <= RDATA;
                        end
                    end

                    IGNORE: begin
                        o_sda <= 1'b1;
                    end

                    default: begin
                        o_sda <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-banged SCCB master on a wired-AND SDA line.
module tb_sccb_slave;

    logic       clk = 1'b0;
    logic       rstn;
    logic       scl;
    logic       m_sda;
    logic       sda_bus;
    logic       o_sda;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] mem [256];

    int passed = 0;
    int total  = 0;

    // Write-strobe monitor state.
    int         wr_cnt   = 0;
    int         bad_inc  = 0;
    int         low_cnt  = 0;
    logic [7:0] wr_addr [16];
    logic [7:0] wr_data [16];
    logic       prev_we  = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & o_sda;
    assign rdata   = mem[addr];

    sccb_slave dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda      (o_sda),
        .o_reg_we   (we),
        .o_reg_addr (addr),
        .o_reg_wdata(wdata),
        .i_reg_rdata(rdata),
        .o_busy     (busy)
    );

    always @(negedge clk) begin
        logic [7:0] nxt;
        nxt = prev_addr + 8'd1;
        if (prev_we && (addr !== nxt || we !== 1'b0)) bad_inc++;
        if (we === 1'b1) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = addr;
                wr_data[wr_cnt] = wdata;
            end
            wr_cnt++;
        end
        if (o_sda === 1'b0) low_cnt++;
        prev_we   = (we === 1'b1);
        prev_addr = addr;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic m_start();
        m_sda = 1'b1; q(); scl = 1'b1; q(); m_sda = 1'b0; q(); scl = 1'b0; q();
    endtask

    task automatic m_stop();
        m_sda = 1'b0; q(); scl = 1'b1; q(); m_sda = 1'b1; q();
    endtask

    task automatic bit_w(input logic b);
        m_sda = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        m_sda = 1'b1; q(); scl = 1'b1; q(); ack = sda_bus; q(); scl = 1'b0; q();
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        m_sda = 1'b1;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            q(); scl = 1'b1; q(); d = {d[6:0], sda_bus}; q(); scl = 1'b0;
        end
        q(); m_sda = nack; q(); scl = 1'b1; q(); q(); scl = 1'b0;
        @(negedge clk); m_sda = 1'b1; q();
    endtask

    task automatic test_reset();
        rstn = 1'b0; scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (o_sda !== 1'b1) $display("FAIL reset_sda: got %b expected 1", o_sda); else passed++;
        total++; if (we !== 1'b0) $display("FAIL reset_we: got %b expected 0", we); else passed++;
        total++; if (addr !== 8'h00) $display("FAIL reset_addr: got %h expected 00", addr); else passed++;
        total++; if (wdata !== 8'h00) $display("FAIL reset_wdata: got %h expected 00", wdata); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        rstn = 1'b1;
        q();
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int base = wr_cnt;
        m_start();
        total++; if (busy !== 1'b1) $display("FAIL write_busy_start: got %b expected 1", busy); else passed++;
        wbyte(8'h42, a0); wbyte(8'h12, a1); wbyte(8'h80, a2);
        total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); else passed++;
        m_stop();
        total++; if (wr_cnt - base !== 1) $display("FAIL write_count: got %0d expected 1", wr_cnt - base); else passed++;
        total++; if (wr_addr[base] !== 8'h12 || wr_data[base] !== 8'h80)
            $display("FAIL write_pair: got %h/%h expected 12/80", wr_addr[base], wr_data[base]); else passed++;
        total++; if (addr !== 8'h13) $display("FAIL write_addr_inc: got %h expected 13", addr); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL write_busy_stop: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        int base = wr_cnt;
        int lbase = low_cnt;
        m_start();
        wbyte(8'h60, a0); wbyte(8'h12, a1); wbyte(8'h80, a2);
        total++; if ({a0, a1, a2} !== 3'b111) $display("FAIL mismatch_acks: got %b expected 111", {a0, a1, a2}); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL mismatch_busy_before_stop: got %b expected 1", busy); else passed++;
        m_stop();
        total++; if (low_cnt - lbase !== 0) $display("FAIL mismatch_sda_low: got %0d low cycles expected 0", low_cnt - lbase); else passed++;
        total++; if (wr_cnt - base !== 0) $display("FAIL mismatch_writes: got %0d expected 0", wr_cnt - base); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mismatch_busy_stop: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d;
        m_start(); wbyte(8'h42, a0); wbyte(8'h0A, a1); m_stop();
        total++; if (addr !== 8'h0A) $display("FAIL read_ptr: got %h expected 0a", addr); else passed++;
        m_start(); wbyte(8'h43, a2);
        total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); else passed++;
        rbyte(1'b1, d);
        total++; if (d !== 8'h76) $display("FAIL read_data: got %h expected 76", d); else passed++;
        total++; if (o_sda !== 1'b1) $display("FAIL read_release: got %b expected 1", o_sda); else passed++;
        // After NACK the slave must stay silent even if the master keeps clocking.
        rbyte(1'b1, d);
        total++; if (d !== 8'hFF) $display("FAIL read_ignore: got %h expected ff", d); else passed++;
        total++; if (addr !== 8'h0A) $display("FAIL read_nack_ptr: got %h expected 0a", addr); else passed++;
        m_stop();
    endtask

    task automatic test_burst_wrap();
        logic a0, a1, a2, a3, a4;
        int base = wr_cnt;
        m_start();
        wbyte(8'h42, a0); wbyte(8'hFE, a1); wbyte(8'hAA, a2); wbyte(8'hBB, a3); wbyte(8'hCC, a4);
        m_stop();
        total++; if ({a0, a1, a2, a3, a4} !== 5'b00000) $display("FAIL burst_acks: got %b expected 00000", {a0, a1, a2, a3, a4}); else passed++;
        total++; if (wr_cnt - base !== 3) $display("FAIL burst_count: got %0d expected 3", wr_cnt - base); else passed++;
        total++; if (wr_addr[base] !== 8'hFE || wr_data[base] !== 8'hAA)
            $display("FAIL burst_w0: got %h/%h expected fe/aa", wr_addr[base], wr_data[base]); else passed++;
        total++; if (wr_addr[base+1] !== 8'hFF || wr_data[base+1] !== 8'hBB)
            $display("FAIL burst_w1: got %h/%h expected ff/bb", wr_addr[base+1], wr_data[base+1]); else passed++;
        total++; if (wr_addr[base+2] !== 8'h00 || wr_data[base+2] !== 8'hCC)
            $display("FAIL burst_w2: got %h/%h expected 00/cc", wr_addr[base+2], wr_data[base+2]); else passed++;
        total++; if (addr !== 8'h01) $display("FAIL burst_final_ptr: got %h expected 01", addr); else passed++;
        total++; if (bad_inc !== 0) $display("FAIL strobe_increment: got %0d bad strobes expected 0", bad_inc); else passed++;
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int base = wr_cnt;
        m_start(); wbyte(8'h42, a0); wbyte(8'h05, a1);
        m_start();
        total++; if (busy !== 1'b1) $display("FAIL rstart_busy: got %b expected 1", busy); else passed++;
        wbyte(8'h43, a2);
        rbyte(1'b0, d0);
        rbyte(1'b1, d1);
        m_stop();
        total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rstart_acks: got %b expected 000", {a0, a1, a2}); else passed++;
        total++; if (d0 !== 8'h5A) $display("FAIL rstart_data0: got %h expected 5a", d0); else passed++;
        total++; if (d1 !== 8'hC3) $display("FAIL rstart_data1: got %h expected c3", d1); else passed++;
        total++; if (addr !== 8'h06) $display("FAIL rstart_ptr: got %h expected 06", addr); else passed++;
        total++; if (wr_cnt - base !== 0) $display("FAIL rstart_writes: got %0d expected 0", wr_cnt - base); else passed++;
    endtask

    task automatic test_reset_midbyte();
        logic a0, a1, a2, a3, a4;
        int base = wr_cnt;
        m_start(); wbyte(8'h42, a0); wbyte(8'h33, a1);
        bit_w(1'b1); bit_w(1'b1); bit_w(1'b1);
        m_sda = 1'b1; q(); scl = 1'b1; q();
        rstn = 1'b0;
        @(negedge clk);
        total++; if ({o_sda, we, busy} !== 3'b100) $display("FAIL midrst_ctrl: got %b expected 100", {o_sda, we, busy}); else passed++;
        total++; if (addr !== 8'h00 || wdata !== 8'h00)
            $display("FAIL midrst_regs: got %h/%h expected 00/00", addr, wdata); else passed++;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        q(); scl = 1'b0; q();
        bit_w(1'b0); bit_w(1'b1); bit_w(1'b0); bit_w(1'b1);
        m_stop();
        total++; if (wr_cnt - base !== 0) $display("FAIL midrst_writes: got %0d expected 0", wr_cnt - base); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passed++;
        base = wr_cnt;
        m_start(); wbyte(8'h42, a2); wbyte(8'h20, a3); wbyte(8'h5C, a4); m_stop();
        total++; if ({a2, a3, a4} !== 3'b000) $display("FAIL midrst_after_acks: got %b expected 000", {a2, a3, a4}); else passed++;
        total++; if (wr_cnt - base !== 1 || wr_addr[base] !== 8'h20 || wr_data[base] !== 8'h5C)
            $display("FAIL midrst_after_write: got %0d %h/%h expected 1 20/5c", wr_cnt - base, wr_addr[base], wr_data[base]); else passed++;
        total++; if (addr !== 8'h21) $display("FAIL midrst_after_ptr: got %h expected 21", addr); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h0A] = 8'h76;
        mem[8'h05] = 8'h5A;
        mem[8'h06] = 8'hC3;
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_burst_wrap();
        test_repeated_start();
        test_reset_midbyte();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
